// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Decode-stage hazard tracker in front of the 8x16 register file read ports.
//   Keeps a small in-flight writer count per architectural register and holds
//   decode (stall) while a source register still has a writer outstanding, or
//   while the destination counter is already at its maximum. Counts are retired
//   by the register file writeback signals and by squashed-writer kills.
//
//   Optional feature macro: WB_BYPASS_EN
//     undefined : a reader waits until the cycle after the last writeback;
//                 fwd1_en/fwd2_en/fwd_data are tied to zero.
//     defined   : a reader may issue in the writeback cycle itself and is told
//                 to take wb_writedata in place of the register file read data.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   dec_valid                decode holds a valid instruction
//   dec_rs_used/dec_rs_sel   first source operand read enable / select
//   dec_rt_used/dec_rt_sel   second source operand read enable / select
//   dec_wr/dec_wr_sel        instruction writes a register / destination
//   wb_write/wb_writeregsel  writeback enable / register (same as rf write port)
//   wb_writedata             writeback data (only used for bypass)
//   kill_valid/kill_regsel   one in-flight writer squashed / its destination
//   stall                    hold decode, nothing issues this cycle
//   err                      sticky counter underflow flag
//   fwd1_en/fwd2_en          substitute fwd_data for read1data / read2data
//   fwd_data                 bypass data (wb_writedata)
module reg_scoreboard #(
  parameter int NREG = 8,
  parameter int SELW = 3,
  parameter int CNTW = 2,
  parameter int DW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dec_valid,
  input  logic            dec_rs_used,
  input  logic [SELW-1:0] dec_rs_sel,
  input  logic            dec_rt_used,
  input  logic [SELW-1:0] dec_rt_sel,
  input  logic            dec_wr,
  input  logic [SELW-1:0] dec_wr_sel,
  input  logic            wb_write,
  input  logic [SELW-1:0] wb_writeregsel,
  input  logic [DW-1:0]   wb_writedata,
  input  logic            kill_valid,
  input  logic [SELW-1:0] kill_regsel,
  output logic            stall,
  output logic            err,
  output logic            fwd1_en,
  output logic            fwd2_en,
  output logic [DW-1:0]   fwd_data
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  // Count after applying one cycle of issue/retire/kill; one extra bit so a
  // retire with no tracked writer shows up as a negative value.
  function automatic logic signed [CNTW:0] net_count(input logic [CNTW-1:0] c,
                                                     input logic inc,
                                                     input logic ret,
                                                     input logic kil);
    logic signed [CNTW:0] s;
    s = $signed({1'b0, c})
      + $signed({{CNTW{1'b0}}, inc})
      - $signed({{CNTW{1'b0}}, ret})
      - $signed({{CNTW{1'b0}}, kil});
    return s;
  endfunction

  // Saturate an underflowed count at zero.
  function automatic logic [CNTW-1:0] clamp_zero(input logic signed [CNTW:0] s);
    return (s < 0) ? '0 : s[CNTW-1:0];
  endfunction

  logic [CNTW-1:0]      cnt [NREG];
  logic signed [CNTW:0] nxt [NREG];
  logic [NREG-1:0]      ret_v;
  logic [NREG-1:0]      kil_v;
  logic [NREG-1:0]      busy_v;
  logic [NREG-1:0]      full_v;
  logic [NREG-1:0]      inc_v;
  logic [NREG-1:0]      under_v;
  logic                 iss;

  always_comb begin
    ret_v = '0;
    kil_v = '0;
    for (int r = 0; r < NREG; r++) begin
      ret_v[r] = wb_write   && (wb_writeregsel == SELW'(r));
      kil_v[r] = kill_valid && (kill_regsel    == SELW'(r));
    end
  end

  always_comb begin
    busy_v = '0;
    full_v = '0;
    for (int r = 0; r < NREG; r++) begin
      // A destination may still issue at the max count if a slot frees this cycle.
      full_v[r] = (cnt[r] == CNT_MAX) && !ret_v[r] && !kil_v[r];
`ifdef WB_BYPASS_EN
      // Busy only if writers remain after this cycle's retire/kill.
      busy_v[r] = (net_count(cnt[r], 1'b0, ret_v[r], kil_v[r]) != 0);
`else
      busy_v[r] = (cnt[r] != '0);
`endif
    end
  end

  assign stall = dec_valid && ((dec_rs_used && busy_v[dec_rs_sel]) ||
                               (dec_rt_used && busy_v[dec_rt_sel]) ||
                               (dec_wr      && full_v[dec_wr_sel]));
  assign iss   = dec_valid && !stall;

  always_comb begin
    inc_v   = '0;
    under_v = '0;
    for (int r = 0; r < NREG; r++) begin
      inc_v[r]   = iss && dec_wr && (dec_wr_sel == SELW'(r));
      nxt[r]     = net_count(cnt[r], inc_v[r], ret_v[r], kil_v[r]);
      under_v[r] = (nxt[r] < 0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      err <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt[r] <= clamp_zero(nxt[r]);
      if (|under_v) err <= 1'b1;
    end
  end

`ifdef WB_BYPASS_EN
  assign fwd1_en  = dec_rs_used && ret_v[dec_rs_sel] && !busy_v[dec_rs_sel];
  assign fwd2_en  = dec_rt_used && ret_v[dec_rt_sel] && !busy_v[dec_rt_sel];
  assign fwd_data = wb_writedata;
`else
  logic unused_wdata;
  assign unused_wdata = ^wb_writedata;
  assign fwd1_en  = 1'b0;
  assign fwd2_en  = 1'b0;
  assign fwd_data = '0;
`endif

endmodule
